fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO, next generation of the team's 128-bit single-clock FIFO. Adds configurable data width and depth, a first-word-fall-through (FWFT) read mode, run-time almost-full/almost-empty thresholds, a fill-level count and sticky overflow/underflow error flags. It sits between a producer and consumer in one clock domain and keeps the existing `i_`/`o_` handshake port set, so current drivers and monitors extend without changes.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_sync_param_if.sv | 36 +++
 rtl/fifo_mem.sv | 26 ++
 rtl/fifo_sync_param.sv | 115 +++++++++++
 tb/tb_fifo_sync_param.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised synchronous FIFO.
package fifo_pkg;

   typedef enum logic {
      FIFO_STD,
      FIFO_FWFT
   } fifo_mode_e;

   localparam int FIFO_MIN_DEPTH = 4;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer port bundle of fifo_sync_param; the FIFO sits on the slave modport.
interface fifo_sync_param_if #(
   parameter int DATA_W = 128,
   parameter int AW     = 4
);
   // Handshake: a write is taken on a rising edge when i_wren=1 and o_full=0; a read is
   // taken when i_rden=1 and o_empty=0. Requests against a blocking flag are dropped
   // and latched in the sticky error flags.
   logic              i_wren;
   logic [DATA_W-1:0] i_wrdata;
   logic              i_rden;
   logic [AW:0]       i_alm_full_thr;
   logic [AW:0]       i_alm_empty_thr;
   logic              i_clr_err;
   logic [DATA_W-1:0] o_rddata;
   logic              o_full;
   logic              o_alm_full;
   logic              o_empty;
   logic              o_alm_empty;
   logic [AW:0]       o_count;
   logic              o_overflow;
   logic              o_underflow;

   modport master (
      output i_wren, i_wrdata, i_rden, i_alm_full_thr, i_alm_empty_thr, i_clr_err,
      input  o_rddata, o_full, o_alm_full, o_empty, o_alm_empty, o_count,
             o_overflow, o_underflow
   );

   modport slave (
      input  i_wren, i_wrdata, i_rden, i_alm_full_thr, i_alm_empty_thr, i_clr_err,
      output o_rddata, o_full, o_alm_full, o_empty, o_alm_empty, o_count,
             o_overflow, o_underflow
   );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port flop array: synchronous write port, asynchronous read port.
module fifo_mem #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_wen,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   // Contents are intentionally left unreset; the count keeps stale words invisible.
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wen) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with STD/FWFT read modes, programmable thresholds,
// fill count and sticky overflow/underflow flags.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int         DATA_W = 128,
   parameter int         DEPTH  = 16,
   parameter fifo_mode_e MODE   = FIFO_STD,
   parameter int         AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   fifo_sync_param_if.slave bus
);

   localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

   if (!is_pow2(DEPTH) || DEPTH < FIFO_MIN_DEPTH) begin : g_bad_depth
      $error("fifo_sync_param: DEPTH must be a power of two and at least FIFO_MIN_DEPTH");
   end

   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              r_overflow;
   logic              r_underflow;
   logic              w_full;
   logic              w_empty;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [DATA_W-1:0] w_mem_rdata;

   // Flags come from the count register alone, so no request input reaches them.
   assign w_full   = (r_count == LP_DEPTH);
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = bus.i_wren & ~w_full;
   assign w_rd_acc = bus.i_rden & ~w_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A new error event in the same cycle as i_clr_err keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.i_wren && w_full) begin
            r_overflow <= 1'b1;
         end else if (bus.i_clr_err) begin
            r_overflow <= 1'b0;
         end
         if (bus.i_rden && w_empty) begin
            r_underflow <= 1'b1;
         end else if (bus.i_clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .i_wen   (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.i_wrdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_mem_rdata)
   );

   if (MODE == FIFO_STD) begin : g_std
      logic [DATA_W-1:0] r_rddata;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_rddata <= '0;
         end else if (w_rd_acc) begin
            r_rddata <= w_mem_rdata;
         end
      end

      assign bus.o_rddata = r_rddata;
   end else begin : g_fwft
      assign bus.o_rddata = w_mem_rdata;
   end

   assign bus.o_full      = w_full;
   assign bus.o_empty     = w_empty;
   assign bus.o_count     = r_count;
   assign bus.o_alm_full  = (r_count >= bus.i_alm_full_thr);
   assign bus.o_alm_empty = (r_count <= bus.i_alm_empty_thr);
   assign bus.o_overflow  = r_overflow;
   assign bus.o_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives an STD-mode and an FWFT-mode FIFO with identical traffic and checks both
// against a queue-based reference model.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(DW), .AW(AW)) if_s ();
  fifo_sync_param_if #(.DATA_W(DW), .AW(AW)) if_f ();

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(FIFO_STD)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (if_s.slave)
  );

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(FIFO_FWFT)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (if_f.slave)
  );

  // reference model
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_std_rd;
  bit            m_ovf;
  bit            m_unf;
  int            af_thr;
  int            ae_thr;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
    if_s.i_wren = wr;  if_f.i_wren = wr;
    if_s.i_wrdata = d; if_f.i_wrdata = d;
    if_s.i_rden = rd;  if_f.i_rden = rd;
    if_s.i_clr_err = clr; if_f.i_clr_err = clr;
    if_s.i_alm_full_thr  = (AW + 1)'(af_thr);
    if_f.i_alm_full_thr  = (AW + 1)'(af_thr);
    if_s.i_alm_empty_thr = (AW + 1)'(ae_thr);
    if_f.i_alm_empty_thr = (AW + 1)'(ae_thr);
  endtask

  task automatic check_dut(input string nm, input bit fwft, input logic [AW:0] count,
                           input logic full, input logic alm_full, input logic empty,
                           input logic alm_empty, input logic ovf, input logic unf,
                           input logic [DW-1:0] rddata);
    int n = exp_q.size();
    check({nm, "_count"},     DW'(count),     DW'(n));
    check({nm, "_full"},      DW'(full),      DW'(n == DEPTH));
    check({nm, "_empty"},     DW'(empty),     DW'(n == 0));
    check({nm, "_alm_full"},  DW'(alm_full),  DW'(n >= af_thr));
    check({nm, "_alm_empty"}, DW'(alm_empty), DW'(n <= ae_thr));
    check({nm, "_overflow"},  DW'(ovf),       DW'(m_ovf));
    check({nm, "_underflow"}, DW'(unf),       DW'(m_unf));
    if (!fwft) check({nm, "_rddata"}, rddata, m_std_rd);
    else if (n > 0) check({nm, "_rddata"}, rddata, exp_q[0]);
  endtask

  task automatic check_all();
    check_dut("std", 1'b0, if_s.o_count, if_s.o_full, if_s.o_alm_full, if_s.o_empty,
              if_s.o_alm_empty, if_s.o_overflow, if_s.o_underflow, if_s.o_rddata);
    check_dut("fwft", 1'b1, if_f.o_count, if_f.o_full, if_f.o_alm_full, if_f.o_empty,
              if_f.o_alm_empty, if_f.o_overflow, if_f.o_underflow, if_f.o_rddata);
  endtask

  task automatic model_edge(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
    int n = exp_q.size();
    if (rd && n > 0) m_std_rd = exp_q.pop_front();
    if (wr && n < DEPTH) exp_q.push_back(d);
    if (wr && n == DEPTH) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (rd && n == 0) m_unf = 1'b1;
    else if (clr) m_unf = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_std_rd = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
    drive(wr, d, rd, clr);
    @(posedge clk);
    model_edge(wr, d, rd, clr);
    #1;
    check_all();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    af_thr = 14;
    ae_thr = 2;
    model_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();

    // fill 0x1..0x10, almost-full at 14
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    check("count_at_full", DW'(if_s.o_count), DW'(16));

    // write+read while full: read taken, write dropped, overflow latched
    step(1'b1, DW'(32'hdead), 1'b1, 1'b0);
    check("count_after_ovf", DW'(if_s.o_count), DW'(15));
    step(1'b0, '0, 1'b0, 1'b1);

    // drain, then one read too many
    while (exp_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("std_rddata_hold", if_s.o_rddata, DW'(16));
    step(1'b0, '0, 1'b0, 1'b1);

    // FWFT head visible without a read
    step(1'b1, DW'(8'ha5), 1'b0, 1'b0);
    check("fwft_head_a5", if_f.o_rddata, DW'(8'ha5));
    step(1'b0, '0, 1'b1, 1'b0);

    // steady fill of 8 across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, rnd_data(), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, rnd_data(), 1'b1, 1'b0);

    // asynchronous reset mid-burst at count 9
    step(1'b1, rnd_data(), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, DW'(32'h1111), 1'b0, 1'b0);
    step(1'b1, DW'(32'h2222), 1'b1, 1'b0);
    check("post_rst_read", if_s.o_rddata, DW'(32'h1111));
    step(1'b0, '0, 1'b1, 1'b0);

    // randomized traffic with shifting bias and live threshold changes
    for (int ph = 0; ph < 8; ph++) begin
      int wr_pct = $urandom_range(10, 90);
      int rd_pct = $urandom_range(10, 90);
      af_thr = $urandom_range(1, DEPTH);
      ae_thr = $urandom_range(0, DEPTH - 1);
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      check_all();
      for (int c = 0; c < 60; c++) begin
        step($urandom_range(0, 99) < wr_pct, rnd_data(),
             $urandom_range(0, 99) < rd_pct, $urandom_range(0, 15) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
